pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Combines the load-use stall request from the hazard detection unit, taken-branch redirects from EX, and data-memory wait states into one set of per-stage register enables and flushes. Sits beside the hazard detection unit and drives the PC, IF/ID, ID/EX, EX/ME and ME/WB pipeline registers. Also tracks a saturating stall-cycle counter and a sticky memory-timeout error.

## Interface
- MEM_TIMEOUT, 16: max consecutive wait cycles for one memory request before error (2..255)
- STALL_CNT_W, 16: width of stall-cycle counter

- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- HDUStall  in  1  load-use hazard from hazard detection unit (decode stage)
- BrTaken_ex  in  1  branch/jump resolved taken in EX
- DMReq_me  in  1  load or store active in ME
- DMAck_me  in  1  data memory completes the ME access this cycle
- PCEn  out  1  PC register enable
- IFIDEn  out  1  IF/ID enable
- IFIDFlush  out  1  IF/ID clears to NOP (wins over enable)
- IDEXEn  out  1  ID/EX enable
- IDEXFlush  out  1  ID/EX clears to NOP (wins over enable)
- EXMEEn  out  1  EX/ME enable
- MEWBFlush  out  1  inject bubble into ME/WB
- MemTimeout  out  1  sticky timeout error
- StallCycles  out  STALL_CNT_W  cycles with PCEn=0, saturating

## Operation
- States: RUN, MEM_WAIT, TIMEOUT. Outputs are Mealy: combinational from state and current inputs.
- RUN, priority high→low:
  - DMReq_me & !DMAck_me: freeze. PCEn=IFIDEn=IDEXEn=EXMEEn=0, MEWBFlush=1. Go to MEM_WAIT, wait count=1.
  - BrTaken_ex: all enables 1, IFIDFlush=1, IDEXFlush=1. HDUStall is ignored because the stalled instruction is squashed.
  - HDUStall: PCEn=0, IFIDEn=0, IDEXFlush=1, IDEXEn=1, EXMEEn=1. Exactly one bubble per asserted cycle.
  - Otherwise all enables 1, all flushes 0.
- MEM_WAIT:
  - !DMAck_me: freeze as above; wait count +1. If count reaches MEM_TIMEOUT, go to TIMEOUT.
  - DMAck_me: evaluate RUN priorities excluding the memory term. Return to RUN and clear the count.
- TIMEOUT: freeze, MemTimeout=1. Left only by reset.
- Any cycle with PCEn=0 increments StallCycles. It saturates at all-ones and does not wrap.
- Wait counter width is $clog2(MEM_TIMEOUT+1).

## Timing
- While rst_n=0: state=RUN, all enables 0, IFIDFlush=IDEXFlush=MEWBFlush=1, MemTimeout=0, StallCycles=0.
- First cycle after release: normal RUN decode.
- Reset mid-MEM_WAIT or in TIMEOUT: immediate return to the reset values. No partial counts persist.
- Latency: 0 cycles from input to enable/flush. State, wait count and StallCycles update on the rising edge.
- Zero-wait memory (DMReq_me & DMAck_me in the same cycle): no stall, stays in RUN.
- Simultaneous events:
  - Memory wait with branch or HDUStall: memory freeze wins. Branch and stall are re-evaluated on the ack cycle, because the upstream stages are frozen and the inputs are held.
  - BrTaken_ex with HDUStall: flush only, no stall cycle counted.
- Timeout: at most MEM_TIMEOUT cycles in MEM_WAIT. The next edge enters TIMEOUT.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - enum ctrl_state_t {RUN, MEM_WAIT, TIMEOUT}
  - default MEM_TIMEOUT constant
  - typedef struct stage_ctrl_t bundling the seven enable/flush bits, reused by the pipeline register wrappers
- One sub-module, sat_counter (parameter W, inc, clr, async active-low reset, saturating). It is instantiated twice: once for the wait count and once for StallCycles.

## Test plan
- Reset:
  - With rst_n=0, expect PCEn=0, all three flushes=1, StallCycles=0.
  - Release with idle inputs: next cycle all enables=1, flushes=0.
- Load-use: HDUStall=1 for one cycle → PCEn=0, IFIDEn=0, IDEXFlush=1 that cycle, StallCycles=1 after the edge.
- Branch with stall: BrTaken_ex=1 and HDUStall=1 together → PCEn=1, IFIDFlush=1, IDEXFlush=1, StallCycles unchanged.
- Memory wait:
  - DMReq_me=1, DMAck_me=0 for 3 cycles, then ack → 3 frozen cycles with MEWBFlush=1.
  - On the ack cycle, enables=1 and the state returns to RUN. StallCycles=3.
- Timeout:
  - MEM_TIMEOUT=4, DMReq_me=1 and never acked → MemTimeout=1 after the 4th wait cycle, stays frozen.
  - Assert rst_n=0 mid-TIMEOUT → MemTimeout=0 immediately.
- Saturation: STALL_CNT_W=3 with 10 stall cycles → StallCycles holds at 7.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   ctrl_state_t : sequencer states
//   stage_ctrl_t : per-stage enable/flush bundle, also used by the
//                  pipeline register wrappers
//   decode_run   : RUN-state priority decode of branch and load-use inputs,
//                  excluding the memory term
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } ctrl_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 16;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exme_en;
        logic mewb_flush;
    } stage_ctrl_t;

    // Held in reset: nothing advances and every flushable register holds a NOP.
    localparam stage_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
        idex_flush: 1'b1, exme_en: 1'b0, mewb_flush: 1'b1
    };

    // Memory wait: everything up to EX/ME holds, a bubble goes into WB.
    localparam stage_ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
        idex_flush: 1'b0, exme_en: 1'b0, mewb_flush: 1'b1
    };

    localparam stage_ctrl_t CTRL_FLOW = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
        idex_flush: 1'b0, exme_en: 1'b1, mewb_flush: 1'b0
    };

    // A taken branch squashes the decode-stage instruction, so a load-use
    // stall raised in the same cycle is dropped.
    function automatic stage_ctrl_t decode_run(input logic br_taken,
                                               input logic hdu_stall);
        stage_ctrl_t c;
        c = CTRL_FLOW;
        if (br_taken) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (hdu_stall) begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count up by one, holds at all-ones
//   clr        : synchronous clear, wins over inc
//   count      : current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges load-use stalls, EX branch redirects and data-memory wait states
// into per-stage enables/flushes. Outputs are combinational from state and
// current inputs (zero-cycle latency).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal decode: memory freeze > branch flush > load-use
//   MEM_WAIT | ME access outstanding, pipeline frozen, wait count running
//   TIMEOUT  | memory never answered; frozen with MemTimeout until reset
//
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   HDUStall, BrTaken_ex           : load-use request, taken branch in EX
//   DMReq_me, DMAck_me             : ME data-memory request / completion
//   PCEn, IFIDEn, IFIDFlush,
//   IDEXEn, IDEXFlush, EXMEEn,
//   MEWBFlush                      : per-stage register controls
//   MemTimeout                     : sticky memory timeout error
//   StallCycles                    : saturating count of cycles with PCEn=0
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   HDUStall,
    input  logic                   BrTaken_ex,
    input  logic                   DMReq_me,
    input  logic                   DMAck_me,
    output logic                   PCEn,
    output logic                   IFIDEn,
    output logic                   IFIDFlush,
    output logic                   IDEXEn,
    output logic                   IDEXFlush,
    output logic                   EXMEEn,
    output logic                   MEWBFlush,
    output logic                   MemTimeout,
    output logic [STALL_CNT_W-1:0] StallCycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t       state, state_nxt;
    stage_ctrl_t       ctrl;
    logic              wait_inc, wait_clr, timeout_err, stall_inc;
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        ctrl        = decode_run(BrTaken_ex, HDUStall);
        state_nxt   = state;
        wait_inc    = 1'b0;
        wait_clr    = 1'b0;
        timeout_err = 1'b0;
        case (state)
            RUN: begin
                // A same-cycle ack is a zero-wait access and never stalls.
                if (DMReq_me && !DMAck_me) begin
                    ctrl      = CTRL_FREEZE;
                    wait_inc  = 1'b1;
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!DMAck_me) begin
                    ctrl     = CTRL_FREEZE;
                    wait_inc = 1'b1;
                    // wait_cnt numbers the current MEM_WAIT cycle (1-based).
                    if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
                        state_nxt = TIMEOUT;
                    end
                end else begin
                    // Upstream inputs were held during the freeze, so the
                    // branch/load-use decode from ctrl's default applies now.
                    wait_clr  = 1'b1;
                    state_nxt = RUN;
                end
            end
            TIMEOUT: begin
                ctrl        = CTRL_FREEZE;
                timeout_err = 1'b1;
            end
            default: begin
                ctrl      = CTRL_FREEZE;
                state_nxt = RUN;
            end
        endcase
        if (!rst_n) begin
            ctrl        = CTRL_RESET;
            timeout_err = 1'b0;
        end
    end

    assign stall_inc = !ctrl.pc_en;

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .count (wait_cnt)
    );

    sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (1'b0),
        .count (StallCycles)
    );

    assign PCEn       = ctrl.pc_en;
    assign IFIDEn     = ctrl.ifid_en;
    assign IFIDFlush  = ctrl.ifid_flush;
    assign IDEXEn     = ctrl.idex_en;
    assign IDEXFlush  = ctrl.idex_flush;
    assign EXMEEn     = ctrl.exme_en;
    assign MEWBFlush  = ctrl.mewb_flush;
    assign MemTimeout = timeout_err;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed testbench for pipeline_stall_ctrl (MEM_TIMEOUT=4, STALL_CNT_W=3).
// Control vector order: {PCEn,IFIDEn,IFIDFlush,IDEXEn,IDEXFlush,EXMEEn,MEWBFlush}
module tb_pipeline_stall_ctrl;

    localparam logic [6:0] V_RESET  = 7'b0010101;
    localparam logic [6:0] V_IDLE   = 7'b1101010;
    localparam logic [6:0] V_LDUSE  = 7'b0001110;
    localparam logic [6:0] V_BRANCH = 7'b1111110;
    localparam logic [6:0] V_FREEZE = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hdu_stall, br_taken, dm_req, dm_ack;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exme_en, mewb_flush;
    logic       mem_timeout;
    logic [2:0] stall_cycles;
    logic [6:0] vec;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(3)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .HDUStall    (hdu_stall),
        .BrTaken_ex  (br_taken),
        .DMReq_me    (dm_req),
        .DMAck_me    (dm_ack),
        .PCEn        (pc_en),
        .IFIDEn      (ifid_en),
        .IFIDFlush   (ifid_flush),
        .IDEXEn      (idex_en),
        .IDEXFlush   (idex_flush),
        .EXMEEn      (exme_en),
        .MEWBFlush   (mewb_flush),
        .MemTimeout  (mem_timeout),
        .StallCycles (stall_cycles)
    );

    assign vec = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exme_en, mewb_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic drive(input logic h, input logic b, input logic r, input logic a);
        hdu_stall = h;
        br_taken  = b;
        dm_req    = r;
        dm_ack    = a;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_vec", 32'(vec), 32'(V_RESET));
        chk("rst_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_tmo", 32'(mem_timeout), 32'd0);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        hdu_stall = 1'b0; br_taken = 1'b0; dm_req = 1'b0; dm_ack = 1'b0;
        #3;
        chk("reset_vec", 32'(vec), 32'(V_RESET));
        chk("reset_cnt", 32'(stall_cycles), 32'd0);
        chk("reset_tmo", 32'(mem_timeout), 32'd0);
        // Reset held across an edge keeps everything at reset values.
        tick();
        chk("reset_hold", 32'(stall_cycles), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        chk("idle_vec", 32'(vec), 32'(V_IDLE));
        tick();
        chk("idle_cnt", 32'(stall_cycles), 32'd0);

        // Load-use: one bubble, one stall cycle.
        drive(1, 0, 0, 0);
        chk("lduse_vec", 32'(vec), 32'(V_LDUSE));
        tick();
        chk("lduse_cnt", 32'(stall_cycles), 32'd1);

        // Branch together with load-use: flush only.
        drive(1, 1, 0, 0);
        chk("br_hdu_vec", 32'(vec), 32'(V_BRANCH));
        tick();
        chk("br_hdu_cnt", 32'(stall_cycles), 32'd1);
        drive(0, 0, 0, 0);
        chk("after_br", 32'(vec), 32'(V_IDLE));

        // Memory wait, three frozen cycles then ack.
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            chk($sformatf("memw_freeze%0d", i), 32'(vec), 32'(V_FREEZE));
            tick();
        end
        drive(0, 0, 1, 1);
        chk("memw_ack_vec", 32'(vec), 32'(V_IDLE));
        tick();
        chk("memw_cnt", 32'(stall_cycles), 32'd3);
        drive(0, 0, 0, 0);
        chk("memw_back_run", 32'(vec), 32'(V_IDLE));

        // Zero-wait access stays in RUN.
        drive(0, 0, 1, 1);
        chk("zero_wait_vec", 32'(vec), 32'(V_IDLE));
        tick();
        chk("zero_wait_cnt", 32'(stall_cycles), 32'd3);
        drive(0, 0, 0, 0);
        chk("zero_wait_run", 32'(vec), 32'(V_IDLE));

        // Longest legal wait: freeze in RUN plus 3 waits, ack on the 4th
        // MEM_WAIT cycle. Also shows the wait count was cleared by the last ack.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 1, 1);
        chk("max_wait_ack", 32'(vec), 32'(V_IDLE));
        chk("max_wait_tmo", 32'(mem_timeout), 32'd0);
        tick();
        drive(0, 0, 0, 0);
        chk("max_wait_run", 32'(vec), 32'(V_IDLE));
        chk("max_wait_tmo2", 32'(mem_timeout), 32'd0);

        // Memory freeze beats branch; branch re-evaluated on the ack cycle.
        pulse_reset();
        drive(0, 1, 1, 0);
        chk("mem_br_freeze", 32'(vec), 32'(V_FREEZE));
        tick();
        drive(0, 1, 1, 1);
        chk("mem_br_ack", 32'(vec), 32'(V_BRANCH));
        tick();
        chk("mem_br_cnt", 32'(stall_cycles), 32'd1);
        drive(0, 0, 0, 0);
        chk("mem_br_run", 32'(vec), 32'(V_IDLE));

        // Memory freeze beats load-use; stall applied on the ack cycle.
        drive(1, 0, 1, 0);
        chk("mem_hdu_freeze", 32'(vec), 32'(V_FREEZE));
        tick();
        drive(1, 0, 1, 1);
        chk("mem_hdu_ack", 32'(vec), 32'(V_LDUSE));
        tick();
        chk("mem_hdu_cnt", 32'(stall_cycles), 32'd3);

        // Saturation at 7 with a 3-bit counter.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        chk("sat_reach", 32'(stall_cycles), 32'd7);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        chk("sat_hold", 32'(stall_cycles), 32'd7);

        // Timeout: RUN freeze, then four MEM_WAIT cycles, then TIMEOUT.
        pulse_reset();
        drive(0, 0, 1, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 1, 0);
            chk($sformatf("tmo_wait%0d", i), 32'(mem_timeout), 32'd0);
            tick();
        end
        drive(0, 0, 1, 0);
        chk("tmo_set", 32'(mem_timeout), 32'd1);
        chk("tmo_freeze", 32'(vec), 32'(V_FREEZE));
        tick();
        drive(0, 0, 0, 1);
        chk("tmo_sticky", 32'(mem_timeout), 32'd1);
        chk("tmo_sticky_vec", 32'(vec), 32'(V_FREEZE));
        tick();
        chk("tmo_cnt_sat", 32'(stall_cycles), 32'd7);

        // Reset inside TIMEOUT returns straight to reset values.
        pulse_reset();
        drive(0, 0, 0, 0);
        chk("post_tmo_run", 32'(vec), 32'(V_IDLE));
        tick();
        chk("post_tmo_tmo", 32'(mem_timeout), 32'd0);
        chk("post_tmo_cnt", 32'(stall_cycles), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
